// File: rtl/esc_sched_pkg.sv
// Shared types and field constants for the ESC pulse scheduler.
// Trigger word layout: [7:6] channel select, [5:0] pulse length in clk cycles.
package esc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] CH_ALL = 2'b00;
    localparam logic [1:0] CH_1   = 2'b01;
    localparam logic [1:0] CH_2   = 2'b10;
    localparam logic [1:0] CH_3   = 2'b11;

    localparam int CH_MSB  = 7;
    localparam int CH_LSB  = 6;
    localparam int LEN_MSB = 5;
    localparam int LEN_LSB = 0;

    typedef logic [7:0] trig_t;

    // One-hot {ESC3, ESC2, ESC1} enable for a channel code; CH_ALL lights every line.
    function automatic logic [2:0] chan_mask(input logic [1:0] ch);
        logic [2:0] m;
        m = 3'b000;
        case (ch)
            CH_ALL:  m = 3'b111;
            CH_1:    m = 3'b001;
            CH_2:    m = 3'b010;
            default: m = 3'b100;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/esc_pulse_sched_if.sv
// Receive strobe / trigger word in, ESC pulse lines and status out.
interface esc_pulse_sched_if
    import esc_sched_pkg::*;
();
    logic  priem;
    trig_t trig;
    logic  en;
    logic  ESC1;
    logic  ESC2;
    logic  ESC3;
    logic  busy;
    logic  fifo_full;
    logic  fifo_empty;
    logic  overflow;

    modport master (
        output priem, trig, en,
        input  ESC1, ESC2, ESC3, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  priem, trig, en,
        output ESC1, ESC2, ESC3, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/esc_pulse_sched_trig_fifo.sv
// DEPTH x 8-bit synchronous FIFO for trigger words, async active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trig_fifo
    import esc_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  trig_t wdata,
    output trig_t rdata,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);

    trig_t       mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        do_push;
    logic        do_pop;

    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/esc_pulse_sched.sv
// ESC1/2/3 pulse scheduler: FIFO-buffered trigger words issued one pulse at a time.
// Optional PRIEM_SYNC_EN: synchronise priem and write once per rising edge.
module esc_pulse_sched
    import esc_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 2
) (
    input logic clk,
    input logic rst,
    esc_pulse_sched_if.slave bus
);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    state_t      state;
    logic [5:0]  cnt;
    logic [GW-1:0] gcnt;
    logic [2:0]  esc;
    logic        busy_r;
    logic        ovf;

    logic        wr_en;
    trig_t       wr_data;
    trig_t       head;
    logic        full;
    logic        empty;
    logic        pop;
    logic [5:0]  head_len;
    logic [1:0]  head_ch;

`ifdef PRIEM_SYNC_EN
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.priem;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // The sender holds trig stable long enough to be sampled on the detected edge.
    assign wr_en   = s2 && !s3;
    assign wr_data = bus.trig;
`else
    assign wr_en   = bus.priem;
    assign wr_data = bus.trig;
`endif

    trig_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_len = head[LEN_MSB:LEN_LSB];
    assign head_ch  = head[CH_MSB:CH_LSB];
    // Zero-length words are popped and discarded without leaving IDLE.
    assign pop      = (state == IDLE) && bus.en && !empty;

    // Full is sampled before any pop this cycle, so a concurrent pop cannot rescue a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (wr_en && full) ovf <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            gcnt   <= '0;
            esc    <= 3'b000;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && head_len != 6'd0) begin
                        cnt    <= head_len;
                        esc    <= chan_mask(head_ch);
                        busy_r <= 1'b1;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == 6'd1) begin
                        cnt <= '0;
                        esc <= 3'b000;
                        if (GAP_CYC == 0) begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gcnt  <= GW'(GAP_CYC);
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                GAP: begin
                    if (gcnt == GW'(1)) begin
                        gcnt   <= '0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: begin
                    esc    <= 3'b000;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ESC1       = esc[0];
    assign bus.ESC2       = esc[1];
    assign bus.ESC3       = esc[2];
    assign bus.busy       = busy_r;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = ovf;

endmodule

// File: tb/tb_esc_pulse_sched.sv
// Scoreboard bench for esc_pulse_sched: a queue-based reference model predicts each
// pulse (lines, start cycle, length) and the status flags; a monitor checks them.
module tb_esc_pulse_sched;

    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 2;

    typedef struct {
        logic [2:0] mask;
        int         rise;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ecount = 0;
    int   checks = 0;
    int   failures = 0;

    esc_pulse_sched_if bus ();

    esc_pulse_sched #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    // Reference model state
    logic [7:0] mq[$];
    exp_t       exp_q[$];
    int         free_at = 0;
    int         busy_until = 0;
    bit         m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, ecount, act, req);
        end
    endtask

    function automatic logic [2:0] exp_mask(input logic [1:0] ch);
        case (ch)
            2'd0:    return 3'b111;
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Predict the effect of the upcoming clock edge given the inputs applied to it.
    task automatic model_edge(input bit p, input logic [7:0] t, input bit e);
        int   n;
        bit   full_before;
        logic [7:0] w;
        int   len;
        exp_t x;
        n = ecount + 1;
        full_before = (mq.size() == DEPTH);
        if (e && mq.size() > 0 && n >= free_at) begin
            w   = mq.pop_front();
            len = int'(w[5:0]);
            if (len == 0) begin
                free_at = n + 1;
            end else begin
                x.mask = exp_mask(w[7:6]);
                x.rise = n;
                x.len  = len;
                exp_q.push_back(x);
                free_at    = n + len + GAP_CYC + 1;
                busy_until = n + len + GAP_CYC;
            end
        end
        if (p) begin
            if (full_before) m_ovf = 1'b1;
            else mq.push_back(t);
        end
    endtask

    task automatic step(input bit p, input logic [7:0] t, input bit e);
        @(negedge clk);
        #1;
        bus.priem = p;
        bus.trig  = t;
        bus.en    = e;
        model_edge(p, t, e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_esc"},   {29'd0, bus.ESC3, bus.ESC2, bus.ESC1}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({tag, "_empty"}, {31'd0, bus.fifo_empty}, 32'd1);
        chk({tag, "_full"},  {31'd0, bus.fifo_full}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, bus.overflow}, 32'd0);
    endtask

    // Assert reset asynchronously mid-cycle; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        mq.delete();
        exp_q.delete();
        free_at    = 0;
        busy_until = 0;
        m_ovf      = 1'b0;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        bus.priem = 1'b0;
        bus.trig  = 8'h00;
        bus.en    = 1'b0;
    endtask

    // Monitor: per-cycle flag checks plus pulse scoreboard
    logic [2:0] mon_esc;
    logic [2:0] prev_esc = 3'b000;
    int         run_len = 0;
    int         rise_at = 0;

    always @(negedge clk) begin
        mon_esc = {bus.ESC3, bus.ESC2, bus.ESC1};
        if (rst) begin
            prev_esc = 3'b000;
            run_len  = 0;
        end else begin
            chk("fifo_full",  {31'd0, bus.fifo_full},  {31'd0, mq.size() == DEPTH});
            chk("fifo_empty", {31'd0, bus.fifo_empty}, {31'd0, mq.size() == 0});
            chk("overflow",   {31'd0, bus.overflow},   {31'd0, m_ovf});
            chk("busy",       {31'd0, bus.busy},       {31'd0, ecount < busy_until});
            if (mon_esc != 3'b000 && prev_esc == 3'b000) begin
                rise_at = ecount;
                run_len = 1;
            end else if (mon_esc != 3'b000) begin
                if (mon_esc != prev_esc) chk("esc_lines_stable", {29'd0, mon_esc}, {29'd0, prev_esc});
                run_len++;
            end else if (prev_esc != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, prev_esc}, 32'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("pulse_lines", {29'd0, prev_esc}, {29'd0, x.mask});
                    chk("pulse_rise",  rise_at, x.rise);
                    chk("pulse_len",   run_len, x.len);
                end
            end
            prev_esc = mon_esc;
        end
    end

    initial begin
        int guard;
        bus.priem = 1'b0;
        bus.trig  = 8'h00;
        bus.en    = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        #1;
        rst = 1'b0;

        // Single ESC1 pulse, len 3
        step(1'b1, 8'b01_000011, 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b1);

        // ESC2 len 2 then ESC3 len 1 on consecutive writes
        step(1'b1, 8'b10_000010, 1'b1);
        step(1'b1, 8'b11_000001, 1'b1);
        repeat (10) step(1'b0, 8'h00, 1'b1);

        // Broadcast, len 4
        step(1'b1, 8'b00_000100, 1'b1);
        repeat (9) step(1'b0, 8'h00, 1'b1);

        // Fill with issue disabled; fifth word overflows
        step(1'b1, 8'b01_000010, 1'b0);
        step(1'b1, 8'b10_000011, 1'b0);
        step(1'b1, 8'b11_000001, 1'b0);
        step(1'b1, 8'b00_000010, 1'b0);
        step(1'b1, 8'b01_000101, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("full_after_4", {31'd0, bus.fifo_full}, 32'd1);
        chk("ovf_after_5",  {31'd0, bus.overflow},  32'd1);
        repeat (30) step(1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // Zero-length word is discarded, next word pulses
        step(1'b1, 8'b01_000000, 1'b1);
        step(1'b1, 8'b01_000010, 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b1);

        // Reset in the middle of a 10-cycle ESC3 pulse, with a queued word behind it
        step(1'b1, 8'b11_001010, 1'b1);
        step(1'b1, 8'b01_000011, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("esc3_mid_pulse", {31'd0, bus.ESC3}, 32'd1);
        do_reset("midrst");
        step(1'b1, 8'b01_000011, 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] ch;
            logic [5:0] len;
            int r;
            ch = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 31);
            if (r == 0)     len = 6'd63;
            else if (r < 5) len = 6'd0;
            else            len = 6'($urandom_range(1, 12));
            step(($urandom_range(0, 2) == 0), {ch, len}, ($urandom_range(0, 9) != 0));
        end

        // Drain
        guard = 0;
        while ((mq.size() != 0 || ecount < busy_until + 1) && guard < 3000) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk("drain_done", {31'd0, guard < 3000}, 32'd1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("idle_lines", {29'd0, bus.ESC3, bus.ESC2, bus.ESC1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esc_pulse_sched.md
Name: esc_pulse_sched

Overview:
- Scheduler that sits in front of the ESC output stage and sequences trigger words into timed ESC1/ESC2/ESC3 pulses.
- Trigger words arrive on the `priem` receive strobe and are buffered in a small FIFO.
- Words are issued strictly in order, one pulse at a time, with a guaranteed low gap between pulses.
- The three ESC lines therefore share one timing engine and never overlap, except in broadcast mode.

Parameters:
- DEPTH, 4, FIFO depth in trigger words; power of 2, at least 2.
- GAP_CYC, 2, minimum all-low cycles between consecutive pulses; 0 allowed.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- priem  in  1  receive strobe; accept `trig` when high.
- trig  in  8  trigger word. [7:6] = channel: 00 all three, 01 ESC1, 10 ESC2, 11 ESC3. [5:0] = pulse length in clk cycles.
- en  in  1  issue enable; when 0, no new word is popped.
- ESC1  out  1  channel 1 pulse (registered).
- ESC2  out  1  channel 2 pulse (registered).
- ESC3  out  1  channel 3 pulse (registered).
- busy  out  1  FSM not in IDLE.
- fifo_full  out  1  FIFO holds DEPTH words.
- fifo_empty  out  1  FIFO holds 0 words.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (async, immediate):
  - ESC1/2/3 = 0, busy = 0, overflow = 0.
  - FIFO cleared: fifo_empty = 1, fifo_full = 0.
  - FSM returns to IDLE; counters cleared.
  - A reset asserted mid-pulse drops the pulse at once; queued words are lost.
- Write path:
  - At a rising edge with priem = 1 and fifo_full = 0, `trig` is pushed.
  - With priem = 1 and fifo_full = 1, the word is dropped and overflow is set.
  - Fullness is judged before any pop in the same cycle, so a simultaneous pop does not rescue the write.
  - Level-sensitive: each high cycle of priem writes one word.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: if en = 1 and FIFO not empty, pop the head word at this edge.
    - len = 0: the word is discarded, no pulse, stay IDLE; the next word can pop on the following edge.
    - len > 0: load cnt = len, set the selected ESC output(s) high, go to PULSE.
  - PULSE: decrement cnt each edge. At the edge where cnt == 1: all ESC outputs go low; go to GAP with gcnt = GAP_CYC, or to IDLE if GAP_CYC = 0.
  - GAP: decrement gcnt each edge; at gcnt == 1 go to IDLE.
- Timing:
  - A word written at edge E0 into an empty FIFO, with the FSM in IDLE and en = 1, raises ESC at E1.
  - The pulse is high for exactly len cycles and falls at E1+len.
  - Back-to-back words: next rise occurs len+GAP_CYC+1 cycles after the previous rise.
- Enable: en = 0 does not truncate an active pulse or gap; it only blocks the pop in IDLE.
- Channel 00 drives ESC1, ESC2 and ESC3 simultaneously with identical timing.
- Maximum length is 63 cycles; the 6-bit counter never wraps.
- FIFO pointers are log2(DEPTH)+1 bits; wrap-around is handled by the MSB compare.

Optional Feature:
- Macro: PRIEM_SYNC_EN.
- Defined:
  - priem passes through a 2-flop synchronizer and a rising-edge detector.
  - Exactly one write per strobe, however long the strobe is held.
  - `trig` is captured with the synchronized edge (sender holds it stable for at least 3 cycles).
  - Adds 2 cycles of latency: E0→E1 becomes E0→E3.
- Undefined: level-sensitive direct write as above.

Decomposition:
- Package esc_sched_pkg:
  - state enum (IDLE, PULSE, GAP);
  - channel codes CH_ALL, CH_1, CH_2, CH_3;
  - field constants: CH_MSB = 7, CH_LSB = 6, LEN_MSB = 5, LEN_LSB = 0;
  - typedef for the 8-bit trigger word.
- Sub-module trig_fifo: parameterised DEPTH × 8-bit synchronous FIFO with push/pop/full/empty, async active-high reset.

Test Plan:
- Reset, then priem one cycle with trig = 8'b01_000011 → ESC1 high for exactly 3 cycles starting 1 edge after the write; ESC2/ESC3 stay 0; busy falls after the 3 + 2 cycles of pulse and gap.
- Writes 8'b10_000010 then 8'b11_000001 on consecutive cycles, GAP_CYC = 2 → ESC2 high 2 cycles; ESC3 rises 5 cycles after the ESC2 rise and is high 1 cycle; no overlap.
- trig = 8'b00_000100 → ESC1, ESC2 and ESC3 all high for the same 4 cycles.
- en = 0, write 5 words with DEPTH = 4 → fifo_full = 1 after 4 writes; the 5th is dropped and overflow = 1 stays set. Set en = 1 → exactly 4 pulses are issued in order.
- Write 8'b01_000000, then 8'b01_000010 → no pulse for the first word; ESC1 high 2 cycles for the second.
- Assert rst in the middle of a 10-cycle ESC3 pulse → ESC3 = 0 immediately (before the next clk edge); fifo_empty = 1, busy = 0; after release, the next word behaves normally.
